// File: rtl/mist_video_pkg.sv
// Shared types, constants and helpers for the MiST video output stage.
// Colour helpers work on 8-bit containers; the width in use is passed explicitly.
package mist_video_pkg;

  // 2x2 ordered-dither thresholds, indexed by {line ^ frame parity, pixel parity}.
  localparam logic [1:0] BAYER2 [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic px_par;
    logic ln_par;
    logic fr_par;
    logic dither;
    logic csync;
  } s1_ctrl_t;

  // Syncs reset inactive so the first pixel after reset neither fakes an edge nor a pulse.
  localparam s1_ctrl_t CtrlRst = '{hs: 1'b1, vs: 1'b1, blank: 1'b1, default: 1'b0};

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } hdmi_px_t;

  localparam hdmi_px_t HdmiRst = '{r: 8'h00, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1, de: 1'b0};

  // a + b clamped to the all-ones value of a 'bits'-wide colour.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b,
                                         input int bits);
    logic [8:0] sum;
    logic [8:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = 9'((1 << bits) - 1);
    return (sum > lim) ? lim[7:0] : sum[7:0];
  endfunction

  // Rescale a from_bits colour to to_bits by repeating its bit pattern from the MSB down.
  function automatic logic [7:0] replicate(input logic [7:0] value, input int from_bits,
                                           input int to_bits);
    logic [7:0] res;
    logic [2:0] src;
    logic [2:0] dst;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < to_bits) begin
        src      = 3'(from_bits - 1 - (i % from_bits));
        dst      = 3'(to_bits - 1 - i);
        res[dst] = value[src];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mist_video_if.sv
// Core-side video inputs and board-side VGA/HDMI pin outputs of the video output stage.
interface mist_video_if #(
  parameter int unsigned IN_BITS  = 8,
  parameter int unsigned OUT_BITS = 6
);
  logic [IN_BITS-1:0]  r_in;
  logic [IN_BITS-1:0]  g_in;
  logic [IN_BITS-1:0]  b_in;
  logic                hs_in;
  logic                vs_in;
  logic                hblank;
  logic                vblank;
  logic [OUT_BITS-1:0] vga_r;
  logic [OUT_BITS-1:0] vga_g;
  logic [OUT_BITS-1:0] vga_b;
  logic                vga_hs;
  logic                vga_vs;
  logic [7:0]          hdmi_r;
  logic [7:0]          hdmi_g;
  logic [7:0]          hdmi_b;
  logic                hdmi_hs;
  logic                hdmi_vs;
  logic                hdmi_de;

  modport master (
    output r_in, g_in, b_in, hs_in, vs_in, hblank, vblank,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs,
    input  hdmi_r, hdmi_g, hdmi_b, hdmi_hs, hdmi_vs, hdmi_de
  );

  modport slave (
    input  r_in, g_in, b_in, hs_in, vs_in, hblank, vblank,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs,
    output hdmi_r, hdmi_g, hdmi_b, hdmi_hs, hdmi_vs, hdmi_de
  );
endinterface

// File: rtl/mist_video_dither.sv
// Stage-2 colour conversion for one channel: ordered dither/truncate, pass-through or
// MSB-replicating expansion, with blanking forced to black.
module mist_video_dither
  import mist_video_pkg::*;
#(
  parameter int unsigned IN_BITS  = 8,
  parameter int unsigned OUT_BITS = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce_pix,
  input  logic                dither_en,
  input  logic                blank,
  input  logic                px_par,
  input  logic                ln_fr_par,
  input  logic [IN_BITS-1:0]  din,
  output logic [OUT_BITS-1:0] dout
);

  localparam int Shift = int'(IN_BITS) - int'(OUT_BITS);

  logic [7:0]          din8;
  logic [7:0]          conv8;
  logic [OUT_BITS-1:0] dout_d, dout_q;
  logic                unused_bits;

  assign din8 = 8'(din);

  if (Shift > 0) begin : g_reduce
    logic [1:0] idx;
    logic [7:0] thr8;

    assign idx = {ln_fr_par, px_par};

    // Threshold is scaled to span exactly the Shift bits that get dropped.
    if (Shift >= 2) begin : g_thr_shl
      assign thr8 = 8'(BAYER2[idx]) << (Shift - 2);
    end else begin : g_thr_shr
      assign thr8 = 8'(BAYER2[idx] >> 1);
    end

    assign conv8 = dither_en ? (sat_add(din8, thr8, IN_BITS) >> Shift) : (din8 >> Shift);
  end else if (Shift == 0) begin : g_pass
    assign conv8 = din8;
  end else begin : g_expand
    assign conv8 = replicate(din8, IN_BITS, OUT_BITS);
  end

  always_comb begin
    dout_d = dout_q;
    if (ce_pix) begin
      dout_d = blank ? '0 : conv8[OUT_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

  // Not every configuration consumes every input or converted bit.
  assign unused_bits = ^{din8, conv8, dither_en, px_par, ln_fr_par};

endmodule

// File: rtl/mist_video_out.sv
// Two-stage pixel pipeline from core RGB/sync to VGA DAC and optional HDMI pins.
// Stage 1 registers inputs and pixel/line/frame parities; stage 2 converts and drives pins.
module mist_video_out
  import mist_video_pkg::*;
#(
  parameter int unsigned IN_BITS  = 8,
  parameter int unsigned OUT_BITS = 6,
  parameter bit          HDMI_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic        dither_en,
  input  logic        csync_en,
  mist_video_if.slave vid
);

  logic [IN_BITS-1:0] r_d, r_q;
  logic [IN_BITS-1:0] g_d, g_q;
  logic [IN_BITS-1:0] b_d, b_q;
  s1_ctrl_t           ctrl_d, ctrl_q;
  logic               vga_hs_d, vga_hs_q;
  logic               vga_vs_d, vga_vs_q;
  logic               ln_fr_par;

  // Stage 1: capture pixel; parities advance only on enabled pixels.
  always_comb begin
    r_d    = r_q;
    g_d    = g_q;
    b_d    = b_q;
    ctrl_d = ctrl_q;
    if (ce_pix) begin
      r_d           = vid.r_in;
      g_d           = vid.g_in;
      b_d           = vid.b_in;
      ctrl_d.hs     = vid.hs_in;
      ctrl_d.vs     = vid.vs_in;
      ctrl_d.blank  = vid.hblank | vid.vblank;
      ctrl_d.px_par = ~vid.hblank & ~ctrl_q.px_par;
      ctrl_d.ln_par = ctrl_q.ln_par ^ (ctrl_q.hs & ~vid.hs_in);
      ctrl_d.fr_par = ctrl_q.fr_par ^ (ctrl_q.vs & ~vid.vs_in);
      ctrl_d.dither = dither_en;
      ctrl_d.csync  = csync_en;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      ctrl_q <= CtrlRst;
    end else begin
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
      ctrl_q <= ctrl_d;
    end
  end

  // Stage 2: VGA syncs, composite when selected.
  always_comb begin
    vga_hs_d = vga_hs_q;
    vga_vs_d = vga_vs_q;
    if (ce_pix) begin
      vga_hs_d = ctrl_q.csync ? ~(ctrl_q.hs ^ ctrl_q.vs) : ctrl_q.hs;
      vga_vs_d = ctrl_q.csync ? 1'b1 : ctrl_q.vs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs_q <= 1'b1;
      vga_vs_q <= 1'b1;
    end else begin
      vga_hs_q <= vga_hs_d;
      vga_vs_q <= vga_vs_d;
    end
  end

  assign vid.vga_hs = vga_hs_q;
  assign vid.vga_vs = vga_vs_q;
  assign ln_fr_par  = ctrl_q.ln_par ^ ctrl_q.fr_par;

  mist_video_dither #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_dither_r (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .dither_en (ctrl_q.dither),
    .blank     (ctrl_q.blank),
    .px_par    (ctrl_q.px_par),
    .ln_fr_par (ln_fr_par),
    .din       (r_q),
    .dout      (vid.vga_r)
  );

  mist_video_dither #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_dither_g (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .dither_en (ctrl_q.dither),
    .blank     (ctrl_q.blank),
    .px_par    (ctrl_q.px_par),
    .ln_fr_par (ln_fr_par),
    .din       (g_q),
    .dout      (vid.vga_g)
  );

  mist_video_dither #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_dither_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .dither_en (ctrl_q.dither),
    .blank     (ctrl_q.blank),
    .px_par    (ctrl_q.px_par),
    .ln_fr_par (ln_fr_par),
    .din       (b_q),
    .dout      (vid.vga_b)
  );

  if (HDMI_EN) begin : g_hdmi
    hdmi_px_t hdmi_d, hdmi_q;

    always_comb begin
      hdmi_d = hdmi_q;
      if (ce_pix) begin
        hdmi_d.r  = ctrl_q.blank ? 8'h00 : replicate(8'(r_q), IN_BITS, 8);
        hdmi_d.g  = ctrl_q.blank ? 8'h00 : replicate(8'(g_q), IN_BITS, 8);
        hdmi_d.b  = ctrl_q.blank ? 8'h00 : replicate(8'(b_q), IN_BITS, 8);
        hdmi_d.hs = ctrl_q.hs;
        hdmi_d.vs = ctrl_q.vs;
        hdmi_d.de = ~ctrl_q.blank;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hdmi_q <= HdmiRst;
      end else begin
        hdmi_q <= hdmi_d;
      end
    end

    assign vid.hdmi_r  = hdmi_q.r;
    assign vid.hdmi_g  = hdmi_q.g;
    assign vid.hdmi_b  = hdmi_q.b;
    assign vid.hdmi_hs = hdmi_q.hs;
    assign vid.hdmi_vs = hdmi_q.vs;
    assign vid.hdmi_de = hdmi_q.de;
  end else begin : g_no_hdmi
    assign vid.hdmi_r  = '0;
    assign vid.hdmi_g  = '0;
    assign vid.hdmi_b  = '0;
    assign vid.hdmi_hs = 1'b0;
    assign vid.hdmi_vs = 1'b0;
    assign vid.hdmi_de = 1'b0;
  end

endmodule

// File: tb/tb_mist_video_out.sv
// Directed bench for mist_video_out: 8->6 main instance plus 4->6 and 6->6 (no HDMI) variants.
module tb_mist_video_out;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce_pix = 1'b0;
  logic dither_en = 1'b0;
  logic csync_en = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  mist_video_if #(.IN_BITS(8), .OUT_BITS(6)) va ();
  mist_video_if #(.IN_BITS(4), .OUT_BITS(6)) vb ();
  mist_video_if #(.IN_BITS(6), .OUT_BITS(6)) vc ();

  mist_video_out #(.IN_BITS(8), .OUT_BITS(6), .HDMI_EN(1'b1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .dither_en(dither_en),
    .csync_en(csync_en), .vid(va)
  );
  mist_video_out #(.IN_BITS(4), .OUT_BITS(6), .HDMI_EN(1'b1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .dither_en(dither_en),
    .csync_en(csync_en), .vid(vb)
  );
  mist_video_out #(.IN_BITS(6), .OUT_BITS(6), .HDMI_EN(1'b0)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .dither_en(dither_en),
    .csync_en(csync_en), .vid(vc)
  );

  typedef struct {
    logic [7:0] r, g, b;
    logic       hb, vb, hs, vs, cs;
    logic [5:0] er, eg, eb;
    logic [7:0] ehr;
    logic       ehs, evs, hhs, hvs, ede;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_a();
    return {1'b0, va.vga_r, va.vga_g, va.vga_b, va.hdmi_r,
            va.vga_hs, va.vga_vs, va.hdmi_hs, va.hdmi_vs, va.hdmi_de};
  endfunction

  // Reset, present one pixel with the given syncs (to flip line/frame parity), then return
  // syncs high and check the first two dithered outputs.
  task automatic dither_seq(input string name, input logic [7:0] r, input logic hs0,
                            input logic vs0, input logic [5:0] e1, input logic [5:0] e2);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n   = 1'b1;
    ce_pix    = 1'b1;
    dither_en = 1'b1;
    csync_en  = 1'b0;
    va.hblank = 1'b0;
    va.vblank = 1'b0;
    va.r_in   = r;
    va.hs_in  = hs0;
    va.vs_in  = vs0;
    tick();
    va.hs_in = 1'b1;
    va.vs_in = 1'b1;
    tick();
    check({name, "_p0"}, 32'(va.vga_r), 32'(e1));
    tick();
    check({name, "_p1"}, 32'(va.vga_r), 32'(e2));
  endtask

  initial begin
    //           r      g      b     hb    vb    hs    vs    cs    er     eg     eb     ehr
    //           ehs   evs   hhs   hvs   ede
    vecs[0] = '{8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h3F, 6'h00, 6'h20, 8'hFF,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{8'h83, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h20, 6'h1F, 6'h00, 8'h83,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{8'hAA, 8'hAA, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 6'h00, 6'h00, 8'h00,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hAA, 8'h55, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h00, 6'h00, 6'h00, 8'h00,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h40, 8'h44, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h10, 6'h11, 6'h00, 8'h40,
                1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'h40, 8'h44, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h10, 6'h11, 6'h00, 8'h40,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h40, 8'h44, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h10, 6'h11, 6'h00, 8'h40,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h40, 8'h44, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h10, 6'h11, 6'h00, 8'h40,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{8'h3C, 8'h00, 8'hFC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h0F, 6'h00, 6'h3F, 8'h3C,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    va.r_in = 8'h00;  va.g_in = 8'h00;  va.b_in = 8'h00;
    va.hs_in = 1'b1;  va.vs_in = 1'b1;  va.hblank = 1'b0;  va.vblank = 1'b0;
    vb.r_in = 4'hA;   vb.g_in = 4'h5;   vb.b_in = 4'hF;
    vb.hs_in = 1'b1;  vb.vs_in = 1'b1;  vb.hblank = 1'b0;  vb.vblank = 1'b0;
    vc.r_in = 6'h2B;  vc.g_in = 6'h00;  vc.b_in = 6'h3F;
    vc.hs_in = 1'b1;  vc.vs_in = 1'b1;  vc.hblank = 1'b0;  vc.vblank = 1'b0;

    repeat (2) @(negedge clk);
    check("reset", pack_a(), {1'b0, 18'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    reset_n = 1'b1;
    ce_pix  = 1'b1;

    // Each vector is held for two enabled pixels, then the pins must show it.
    for (int i = 0; i < 9; i++) begin
      va.r_in = vecs[i].r;   va.g_in = vecs[i].g;    va.b_in = vecs[i].b;
      va.hblank = vecs[i].hb; va.vblank = vecs[i].vb;
      va.hs_in = vecs[i].hs; va.vs_in = vecs[i].vs;  csync_en = vecs[i].cs;
      tick();
      tick();
      check($sformatf("vec%0d", i), pack_a(),
            {1'b0, vecs[i].er, vecs[i].eg, vecs[i].eb, vecs[i].ehr,
             vecs[i].ehs, vecs[i].evs, vecs[i].hhs, vecs[i].hvs, vecs[i].ede});
    end

    // Pipeline freeze with ce_pix low while inputs change.
    ce_pix    = 1'b0;
    va.r_in   = 8'hFF;
    va.hblank = 1'b1;
    va.hs_in  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("freeze%0d", k), 32'({va.vga_r, va.hdmi_de, va.vga_hs}),
            32'({6'h0F, 1'b1, 1'b1}));
    end
    ce_pix = 1'b1;
    tick();
    check("resume_old", 32'({va.vga_r, va.hdmi_de}), 32'({6'h0F, 1'b1}));
    tick();
    check("blank_on", 32'({va.vga_r, va.hdmi_r, va.hdmi_de}), 32'({6'h00, 8'h00, 1'b0}));
    va.hblank = 1'b0;
    va.r_in   = 8'h11;
    tick();
    check("de_lag", 32'({va.vga_r, va.hdmi_de, va.vga_hs}), 32'({6'h00, 1'b0, 1'b0}));
    tick();
    check("de_rise", 32'({va.vga_r, va.hdmi_r, va.hdmi_de}), 32'({6'h04, 8'h11, 1'b1}));

    // Reset asserted between clock edges must act at once.
    #2 reset_n = 1'b0;
    #1 check("async_reset", pack_a(), {1'b0, 18'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    reset_n  = 1'b1;
    va.hs_in = 1'b1;

    // 0x82 + {0,2,3,1} >> 2 distinguishes every threshold pairing; 0xFF must saturate.
    dither_seq("dith_plain", 8'h82, 1'b1, 1'b1, 6'h21, 6'h20);
    dither_seq("dith_line",  8'h82, 1'b0, 1'b1, 6'h20, 6'h21);
    dither_seq("dith_frame", 8'h82, 1'b1, 1'b0, 6'h20, 6'h21);
    dither_seq("dith_both",  8'h82, 1'b0, 1'b0, 6'h21, 6'h20);
    dither_seq("sat_even",   8'hFF, 1'b1, 1'b1, 6'h3F, 6'h3F);
    dither_seq("sat_odd",    8'hFF, 1'b0, 1'b1, 6'h3F, 6'h3F);

    // Variants ran alongside with constant inputs and dither_en now high.
    check("expand_4to6", 32'({vb.vga_r, vb.vga_g, vb.vga_b, vb.hdmi_r}),
          32'({6'h2A, 6'h15, 6'h3F, 8'hAA}));
    check("pass_6_nohdmi", 32'({vc.vga_r, vc.vga_b, vc.hdmi_r, vc.hdmi_de, vc.hdmi_hs}),
          32'({6'h2B, 6'h3F, 8'h00, 1'b0, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
